// File: rtl/uart_line_loader_pkg.sv
// Shared definitions for the UART line loader: command bytes, ASCII digit
// bounds, parser state encoding and panel-setting reset values.
package uart_line_loader_pkg;

    localparam logic [7:0] CMD_LINE   = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_BRIGHT = 8'h42;  // 'B'
    localparam logic [7:0] CMD_RGBEN  = 8'h45;  // 'E'
    localparam logic [7:0] ASCII_0    = 8'h30;  // '0'
    localparam logic [7:0] ASCII_9    = 8'h39;  // '9'

    localparam logic [5:0] BRIGHT_RESET = 6'h3F;
    localparam logic [2:0] RGB_RESET    = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW_HI,
        ST_ROW_LO,
        ST_DATA,
        ST_BRIGHT,
        ST_RGBEN
    } state_e;

    // True for the ASCII characters '0'..'9'.
    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/uart_line_loader_timeout.sv
// Inter-byte watchdog for the line loader: a loadable down-counter that
// flags expiry once it has counted down to zero while enabled.
module loader_timeout #(
    parameter int WIDTH = 20,
    parameter int TICKS = 1000000
) (
    input  logic clk_in,
    input  logic reset_n,
    input  logic reload_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [WIDTH-1:0] LOAD = WIDTH'(TICKS);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Reload wins over counting; the counter parks at zero rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (reload_i) begin
            count_d = LOAD;
        end else if (enable_i && (count_q != '0)) begin
            count_d = count_q - ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= LOAD;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/uart_line_loader.sv
// Parses the matrix UART byte stream into framebuffer row writes ('L'),
// brightness mask updates ('B') and channel enable updates ('E').
module uart_line_loader
    import uart_line_loader_pkg::*;
#(
    parameter int ROWS          = 32,
    parameter int BYTES_PER_ROW = 128,
    parameter int ADDR_WIDTH    = 12,
    parameter int TIMEOUT_WIDTH = 20,
    parameter int TIMEOUT_TICKS = 1000000
) (
    input  logic                  clk_in,
    input  logic                  reset_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [7:0]            ram_data_out,
    output logic                  ram_write_enable,
    output logic                  ram_clk_enable,
    output logic [5:0]            brightness_enable,
    output logic [2:0]            rgb_enable,
    output logic                  busy,
    output logic                  line_done,
    output logic                  cmd_error,
    output logic [2:0]            state_dbg
);

    localparam int IDX_W = $clog2(BYTES_PER_ROW);
    localparam int ROW_W = ADDR_WIDTH - IDX_W;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES_PER_ROW - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [6:0]       ROWS_7   = 7'(ROWS);

    state_e                  state_q;
    logic [3:0]              tens_q;
    logic [ROW_W-1:0]        row_q;
    logic [IDX_W-1:0]        idx_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              data_q;
    logic                    we_q;
    logic                    done_q;
    logic                    err_q;
    logic [5:0]              bright_q;
    logic [2:0]              rgb_q;
    logic [6:0]              row_sum;
    logic                    tmo_expired;

    // Decimal row number: the low nibble of an ASCII digit is its value.
    assign row_sum = ({3'b000, tens_q} * 7'd10) + {3'b000, rx_data[3:0]};

    loader_timeout #(
        .WIDTH (TIMEOUT_WIDTH),
        .TICKS (TIMEOUT_TICKS)
    ) u_timeout (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .reload_i  (rx_valid),
        .enable_i  (state_q != ST_IDLE),
        .expired_o (tmo_expired)
    );

    // Parser FSM plus the one-stage write pipeline; a byte in the expiry cycle wins over the abort.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            tens_q   <= '0;
            row_q    <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            bright_q <= BRIGHT_RESET;
            rgb_q    <= RGB_RESET;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (rx_valid) begin
                case (state_q)
                    ST_IDLE: begin
                        case (rx_data)
                            CMD_LINE:   state_q <= ST_ROW_HI;
                            CMD_BRIGHT: state_q <= ST_BRIGHT;
                            CMD_RGBEN:  state_q <= ST_RGBEN;
                            default:    state_q <= ST_IDLE;
                        endcase
                    end
                    ST_ROW_HI: begin
                        if (is_digit(rx_data)) begin
                            tens_q  <= rx_data[3:0];
                            state_q <= ST_ROW_LO;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_ROW_LO: begin
                        if (is_digit(rx_data) && (row_sum < ROWS_7)) begin
                            row_q   <= row_sum[ROW_W-1:0];
                            idx_q   <= '0;
                            state_q <= ST_DATA;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        we_q   <= 1'b1;
                        addr_q <= {row_q, idx_q};
                        data_q <= rx_data;
                        idx_q  <= idx_q + IDX_ONE;
                        if (idx_q == IDX_LAST) begin
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_BRIGHT: begin
                        bright_q <= rx_data[5:0];
                        state_q  <= ST_IDLE;
                    end
                    ST_RGBEN: begin
                        rgb_q   <= rx_data[2:0];
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end else if ((state_q != ST_IDLE) && tmo_expired) begin
                err_q   <= 1'b1;
                state_q <= ST_IDLE;
            end
        end
    end

    assign ram_address       = addr_q;
    assign ram_data_out      = data_q;
    assign ram_write_enable  = we_q;
    assign ram_clk_enable    = we_q;
    assign brightness_enable = bright_q;
    assign rgb_enable        = rgb_q;
    assign busy              = (state_q != ST_IDLE);
    assign line_done         = done_q;
    assign cmd_error         = err_q;
    assign state_dbg         = state_q;

endmodule

// File: tb/tb_uart_line_loader.sv
// Self-checking bench for uart_line_loader: command-level reference model,
// write scoreboard, table-driven header/settings vectors and timing corners.
module tb_uart_line_loader;

    localparam int T = 300;  // shortened inter-byte timeout for simulation

    logic        clk_in = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [11:0] ram_address;
    logic [7:0]  ram_data_out;
    logic        ram_write_enable;
    logic        ram_clk_enable;
    logic [5:0]  brightness_enable;
    logic [2:0]  rgb_enable;
    logic        busy;
    logic        line_done;
    logic        cmd_error;
    logic [2:0]  state_dbg;

    uart_line_loader #(.TIMEOUT_TICKS(T)) dut (
        .clk_in            (clk_in),
        .reset_n           (reset_n),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .ram_address       (ram_address),
        .ram_data_out      (ram_data_out),
        .ram_write_enable  (ram_write_enable),
        .ram_clk_enable    (ram_clk_enable),
        .brightness_enable (brightness_enable),
        .rgb_enable        (rgb_enable),
        .busy              (busy),
        .line_done         (line_done),
        .cmd_error         (cmd_error),
        .state_dbg         (state_dbg)
    );

    // Clock / watchdog
    always #5 clk_in = ~clk_in;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, limit 1000000 ns");
        $fatal(1, "watchdog");
    end

    // Check bookkeeping
    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: buffers the open command as a byte list and interprets it.
    logic [7:0]  cmd_buf[$];
    logic [19:0] exp_q[$];
    int          exp_err = 0;
    int          exp_done = 0;
    logic [5:0]  exp_bright = 6'h3F;
    logic [2:0]  exp_rgb = 3'b111;

    function automatic bit is_dig(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int row;
        int k;
        if (cmd_buf.size() == 0) begin
            if (b == "L" || b == "B" || b == "E") cmd_buf.push_back(b);
        end else if (cmd_buf[0] == "B") begin
            exp_bright = b[5:0];
            cmd_buf.delete();
        end else if (cmd_buf[0] == "E") begin
            exp_rgb = b[2:0];
            cmd_buf.delete();
        end else begin
            cmd_buf.push_back(b);
            if (cmd_buf.size() <= 3) begin
                if (!is_dig(b)) begin
                    exp_err++;
                    cmd_buf.delete();
                end else if (cmd_buf.size() == 3) begin
                    row = (int'(cmd_buf[1]) - 48) * 10 + (int'(cmd_buf[2]) - 48);
                    if (row >= 32) begin
                        exp_err++;
                        cmd_buf.delete();
                    end
                end
            end else begin
                k = cmd_buf.size() - 4;
                row = (int'(cmd_buf[1]) - 48) * 10 + (int'(cmd_buf[2]) - 48);
                exp_q.push_back({12'(row * 128 + k), b});
                if (k == 127) begin
                    exp_done++;
                    cmd_buf.delete();
                end
            end
        end
    endtask

    task automatic model_timeout();
        if (cmd_buf.size() != 0) begin
            exp_err++;
            cmd_buf.delete();
        end
    endtask

    task automatic model_reset();
        cmd_buf.delete();
        exp_q.delete();
        exp_bright = 6'h3F;
        exp_rgb = 3'b111;
    endtask

    // Scoreboard / monitor, sampled on the falling edge
    int          err_seen = 0;
    int          done_seen = 0;
    int          unexp_wr = 0;
    int          we_run = 0;
    int          max_run = 0;
    logic [11:0] last_addr = '0;
    logic [19:0] exp_wr;

    always @(negedge clk_in) begin
        if (reset_n) begin
            if (ram_write_enable) begin
                we_run++;
                if (we_run > max_run) max_run = we_run;
                last_addr = ram_address;
                check("ram_clk_enable_with_we", 32'(ram_clk_enable), 32'd1);
                if (exp_q.size() == 0) begin
                    unexp_wr++;
                end else begin
                    exp_wr = exp_q.pop_front();
                    check("write_addr_data", {12'h0, ram_address, ram_data_out}, {12'h0, exp_wr});
                end
            end else begin
                we_run = 0;
                if (ram_clk_enable) check("ram_clk_enable_without_we", 32'(ram_clk_enable), 32'd0);
            end
            if (line_done) begin
                done_seen++;
                check("line_done_on_last_write", {24'h0, ram_write_enable, ram_address[6:0]}, {24'h0, 1'b1, 7'h7F});
            end
            if (cmd_error) begin
                err_seen++;
                check("error_done_exclusive", 32'(line_done), 32'd0);
            end
        end
    end

    // Driver tasks; each returns 1 ns after a rising edge
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_valid = 1'b1;
        model_byte(b);
        @(posedge clk_in);
        #1;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic send_header(input logic [7:0] c, input logic [7:0] d1, input logic [7:0] d0);
        send_byte(c, 0);
        send_byte(d1, 0);
        send_byte(d0, 0);
    endtask

    task automatic end_segment(input string name);
        repeat (4) begin
            @(posedge clk_in);
            #1;
        end
        check({name, "_unexpected_writes"}, 32'(unexp_wr), 32'd0);
        check({name, "_missing_writes"}, 32'(exp_q.size()), 32'd0);
        check({name, "_cmd_error_count"}, 32'(err_seen), 32'(exp_err));
        check({name, "_line_done_count"}, 32'(done_seen), 32'(exp_done));
        check({name, "_busy"}, 32'(busy), 32'(cmd_buf.size() != 0));
        check({name, "_settings"}, {23'h0, brightness_enable, rgb_enable}, {23'h0, exp_bright, exp_rgb});
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_addr_data"}, {12'h0, ram_address, ram_data_out}, 32'h0);
        check({name, "_strobes"}, {27'h0, ram_write_enable, ram_clk_enable, busy, line_done, cmd_error}, 32'h0);
        check({name, "_settings"}, {23'h0, brightness_enable, rgb_enable}, {23'h0, 6'h3F, 3'b111});
    endtask

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        int         exp_err;
    } hdr_vec_t;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] arg;
        logic [5:0] exp_bright;
        logic [2:0] exp_rgb;
    } set_vec_t;

    hdr_vec_t hdr_tab[6];
    set_vec_t set_tab[5];

    // Main sequence
    initial begin
        int waited;
        int err_before;

        hdr_tab[0] = '{"3", "X", 1};
        hdr_tab[1] = '{"3", "2", 1};
        hdr_tab[2] = '{"9", "9", 1};
        hdr_tab[3] = '{8'h2F, "0", 1};
        hdr_tab[4] = '{8'h3A, "0", 1};
        hdr_tab[5] = '{"3", "L", 1};

        set_tab[0] = '{"B", 8'h15, 6'h15, 3'b111};
        set_tab[1] = '{"E", 8'h06, 6'h15, 3'b110};
        set_tab[2] = '{"B", 8'hC0, 6'h00, 3'b110};
        set_tab[3] = '{"E", 8'hF9, 6'h00, 3'b001};
        set_tab[4] = '{"B", 8'h15, 6'h15, 3'b001};

        // Reset with bytes arriving that must be ignored
        reset_n = 1'b0;
        repeat (3) begin
            @(posedge clk_in);
            #1;
            rx_data = "L";
            rx_valid = 1'($urandom_range(0, 1));
        end
        rx_valid = 1'b0;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk_in);
        #1;
        check_reset_outputs("after_reset");

        // 1: row 05, data = index
        send_header("L", "0", "5");
        for (int i = 0; i < 128; i++) send_byte(8'(i), $urandom_range(0, 2));
        end_segment("row05");
        check("row05_last_addr", 32'(last_addr), 32'h2FF);

        // 2: row 31, payload back-to-back every cycle
        max_run = 0;
        send_header("L", "3", "1");
        for (int i = 0; i < 128; i++) send_byte(8'hAA, 0);
        end_segment("row31");
        check("row31_consecutive_writes", 32'(max_run), 32'd128);
        check("row31_last_addr", 32'(last_addr), 32'hFFF);

        // 3: malformed headers, then a good row whose payload contains command bytes
        for (int v = 0; v < 6; v++) begin
            err_before = err_seen;
            send_header("L", hdr_tab[v].hi, hdr_tab[v].lo);
            repeat (3) begin
                @(posedge clk_in);
                #1;
            end
            check($sformatf("bad_header_%0d_error", v), 32'(err_seen - err_before), 32'(hdr_tab[v].exp_err));
            check($sformatf("bad_header_%0d_busy", v), 32'(busy), 32'd0);
        end
        send_header("L", "0", "0");
        for (int i = 0; i < 128; i++) send_byte((i % 3 == 0) ? 8'h4C : 8'(i ^ 8'h0A), $urandom_range(0, 1));
        end_segment("headers");

        // 4: settings table
        for (int v = 0; v < 5; v++) begin
            send_byte(set_tab[v].cmd, 0);
            send_byte(set_tab[v].arg, 1);
            check($sformatf("setting_%0d", v), {23'h0, brightness_enable, rgb_enable},
                  {23'h0, set_tab[v].exp_bright, set_tab[v].exp_rgb});
        end
        end_segment("settings");

        // 5a: row 01 abandoned after 10 bytes
        send_header("L", "0", "1");
        for (int i = 0; i < 10; i++) send_byte(8'(8'h50 + i), 0);
        waited = 0;
        while (!cmd_error && waited < T + 20) begin
            @(posedge clk_in);
            #1;
            waited++;
        end
        check("timeout_latency", 32'(waited), 32'(T + 1));
        model_timeout();
        end_segment("timeout");

        // 5b: byte arriving in the expiry cycle keeps the command alive
        send_header("L", "0", "1");
        for (int i = 0; i < 10; i++) send_byte(8'(8'h60 + i), 0);
        repeat (T) begin
            @(posedge clk_in);
            #1;
        end
        for (int i = 10; i < 128; i++) send_byte(8'(8'h60 + i), 0);
        end_segment("expiry_byte");

        // 6: reset in the middle of a row, then a fresh row loads
        send_header("L", "0", "2");
        for (int i = 0; i < 40; i++) send_byte(8'($urandom_range(0, 255)), 0);
        @(posedge clk_in);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        repeat (2) begin
            @(posedge clk_in);
            #1;
            rx_valid = 1'b1;
            rx_data = "E";
        end
        rx_valid = 1'b0;
        reset_n = 1'b1;
        @(posedge clk_in);
        #1;
        send_header("L", "0", "2");
        for (int i = 0; i < 128; i++) send_byte(8'(255 - i), $urandom_range(0, 1));
        end_segment("after_mid_reset");
        check("after_mid_reset_last_addr", 32'(last_addr), 32'h17F);

        // Randomized command stream checked against the model
        for (int n = 0; n < 10; n++) begin
            int kind;
            int row;
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    row = $urandom_range(0, 31);
                    send_header("L", 8'(48 + row / 10), 8'(48 + row % 10));
                    for (int i = 0; i < 128; i++) send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 2));
                end
                1: begin
                    send_byte("B", $urandom_range(0, 2));
                    send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 2));
                end
                2: begin
                    send_byte("E", $urandom_range(0, 2));
                    send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 2));
                end
                default: begin
                    row = $urandom_range(0, 99);
                    send_header("L", 8'(48 + row / 10), 8'(48 + row % 10));
                    if (row < 32) begin
                        for (int i = 0; i < 128; i++) send_byte(8'($urandom_range(0, 255)), 0);
                    end
                    send_byte(8'h0D, 0);
                    send_byte(8'h20, 0);
                end
            endcase
        end
        end_segment("random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
